// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction fetch bus between sequencer and instruction memory
interface control_unit_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     instr;

   modport master (output imem_req, imem_addr, input imem_ack, instr);
   modport slave  (input imem_req, imem_addr, output imem_ack, instr);
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/exec/wb sequencer driving the RF + ALU datapath
module control_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   control_unit_if.master       imem,
   input  logic                 N,
   input  logic                 Z,
   input  logic                 V,
   input  logic                 C,
   output logic                 RF_en,
   output logic [2:0]           RF_addr,
   output logic [2:0]           read_A,
   output logic [2:0]           read_B,
   output logic                 add_or_sub,
   output logic                 out_imm,
   output logic [15:0]          ext_B_data,
   output logic                 LHI,
   output logic                 LLI,
   output logic                 ctro_outR,
   output logic                 halted,
   output logic                 illegal
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_ADDI = 5'b00011;
   localparam logic [4:0] OP_SUBI = 5'b00100;
   localparam logic [4:0] OP_LHI  = 5'b00101;
   localparam logic [4:0] OP_LLI  = 5'b00110;
   localparam logic [4:0] OP_OUT  = 5'b00111;
   localparam logic [4:0] OP_BZ   = 5'b01000;
   localparam logic [4:0] OP_JMP  = 5'b01001;
   localparam logic [4:0] OP_HALT = 5'b11111;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [15:0]     ir;
   logic [3:0]      flags;
   logic            ir_load, flag_load, set_halt, set_illegal;

   logic [4:0] op;
   logic [7:0] imm8;
   logic [PC_W-1:0] br_target;

   assign op        = ir[15:11];
   assign imm8      = ir[7:0];
   assign br_target = pc + PC_W'($signed(imm8));
   assign imem.imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         flags   <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (ir_load)     ir      <= imem.instr;
         if (flag_load)   flags   <= {N, Z, V, C};
         if (set_halt)    halted  <= 1'b1;
         if (set_illegal) illegal <= 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      imem.imem_req = 1'b0;
      RF_en         = 1'b0;
      ctro_outR     = 1'b0;
      ir_load       = 1'b0;
      flag_load     = 1'b0;
      set_halt      = 1'b0;
      set_illegal   = 1'b0;
      case (state)
         S_FETCH: begin
            imem.imem_req = ~rst;
            if (imem.imem_ack) begin
               ir_load   = 1'b1;
               pc_nxt    = pc + 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            state_nxt = S_FETCH;
            case (op)
               OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
                  flag_load = 1'b1;
                  state_nxt = S_WB;
               end
               OP_LHI, OP_LLI: state_nxt = S_WB;
               OP_OUT:         ctro_outR = 1'b1;
               OP_BZ:          if (flags[2]) pc_nxt = br_target;
               OP_JMP:         pc_nxt = br_target;
               OP_HALT: begin
                  set_halt  = 1'b1;
                  state_nxt = S_HALT;
               end
               OP_NOP:  ;
               default: set_illegal = 1'b1;
            endcase
         end
         S_WB: begin
            RF_en     = 1'b1;
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_HALT;
      endcase
   end

   // Datapath controls decode straight from IR, so they change only when IR reloads at the start of DECODE.
   always_comb begin
      read_A     = ir[7:5];
      read_B     = ir[4:2];
      RF_addr    = ir[10:8];
      add_or_sub = (op == OP_SUB) || (op == OP_SUBI);
      out_imm    = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LHI) || (op == OP_LLI);
      LHI        = (op == OP_LHI);
      LLI        = (op == OP_LLI);
      ext_B_data = '0;
      if ((op == OP_ADDI) || (op == OP_SUBI))
         ext_B_data = {{11{ir[4]}}, ir[4:0]};
      else if ((op == OP_LHI) || (op == OP_LLI))
         ext_B_data = {8'h00, imm8};
   end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic N = 1'b0, Z = 1'b0, V = 1'b0, C = 1'b0;
   logic RF_en, add_or_sub, out_imm, LHI, LLI, ctro_outR, halted, illegal;
   logic [2:0] RF_addr, read_A, read_B;
   logic [15:0] ext_B_data;
   logic [15:0] mem [256];
   int wait_cycles = 0;
   int cnt = 0;
   int checks = 0;
   int errors = 0;

   control_unit_if #(.PC_W(8)) bus ();

   control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .imem(bus),
      .N(N), .Z(Z), .V(V), .C(C),
      .RF_en(RF_en), .RF_addr(RF_addr), .read_A(read_A), .read_B(read_B),
      .add_or_sub(add_or_sub), .out_imm(out_imm), .ext_B_data(ext_B_data),
      .LHI(LHI), .LLI(LLI), .ctro_outR(ctro_outR), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Instruction memory: acks after wait_cycles cycles of held request.
   initial begin
      bus.imem_ack = 1'b0;
      bus.instr    = 16'h0000;
   end
   always @(negedge clk) begin
      if (bus.imem_req) begin
         if (cnt == wait_cycles) begin
            bus.imem_ack = 1'b1;
            bus.instr    = mem[bus.imem_addr];
            cnt = 0;
         end else begin
            bus.imem_ack = 1'b0;
            cnt++;
         end
      end else begin
         bus.imem_ack = 1'b0;
         cnt = 0;
      end
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task clear_mem;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task do_reset;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   task test_reset;
      rst = 1'b1;
      tick; tick;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.imem_addr); end
      checks++; if ({RF_en, ctro_outR, halted, illegal, out_imm, LHI, LLI, add_or_sub} !== 8'h00)
         begin errors++; $display("FAIL reset_ctrl got %b exp 00000000", {RF_en, ctro_outR, halted, illegal, out_imm, LHI, LLI, add_or_sub}); end
      checks++; if ({ext_B_data, RF_addr, read_A, read_B} !== 25'h0)
         begin errors++; $display("FAIL reset_data got %h exp 0", {ext_B_data, RF_addr, read_A, read_B}); end
   endtask

   task test_alu;
      clear_mem;
      mem[0] = 16'h1905;
      mem[1] = 16'h0A24;
      do_reset;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL alu_fetch_req got %b exp 1", bus.imem_req); end
      tick;
      checks++; if ({RF_addr, out_imm, add_or_sub, ext_B_data} !== {3'd1, 1'b1, 1'b0, 16'h0005})
         begin errors++; $display("FAIL alu_addi_decode got %h exp %h", {RF_addr, out_imm, add_or_sub, ext_B_data}, {3'd1, 1'b1, 1'b0, 16'h0005}); end
      tick;
      checks++; if (RF_en !== 1'b0) begin errors++; $display("FAIL alu_exec_rf_en got %b exp 0", RF_en); end
      tick;
      checks++; if ({RF_en, RF_addr} !== {1'b1, 3'd1}) begin errors++; $display("FAIL alu_wb1 got %b exp 1001", {RF_en, RF_addr}); end
      tick;
      checks++; if ({RF_en, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h01})
         begin errors++; $display("FAIL alu_fetch2 got %h exp %h", {RF_en, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 8'h01}); end
      tick;
      checks++; if ({read_A, read_B, out_imm, add_or_sub, ext_B_data} !== {3'd1, 3'd1, 1'b0, 1'b0, 16'h0000})
         begin errors++; $display("FAIL alu_add_decode got %h exp %h", {read_A, read_B, out_imm, add_or_sub, ext_B_data}, {3'd1, 3'd1, 1'b0, 1'b0, 16'h0000}); end
      tick; tick;
      checks++; if ({RF_en, RF_addr} !== {1'b1, 3'd2}) begin errors++; $display("FAIL alu_wb2 got %b exp 1010", {RF_en, RF_addr}); end
   endtask

   task test_wait;
      clear_mem;
      wait_cycles = 3;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({bus.imem_req, bus.imem_addr, RF_en, ctro_outR, ext_B_data, read_A} !== {1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 3'd0})
            begin errors++; $display("FAIL wait_hold%0d got %h exp %h", i, {bus.imem_req, bus.imem_addr, RF_en, ctro_outR, ext_B_data, read_A}, {1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 3'd0}); end
         tick;
      end
      checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b0, 8'h01})
         begin errors++; $display("FAIL wait_after_ack got %h exp %h", {bus.imem_req, bus.imem_addr}, {1'b0, 8'h01}); end
      wait_cycles = 0;
   endtask

   task test_branch(input logic z_in, input logic [7:0] exp_pc);
      clear_mem;
      mem[0] = 16'h114C;
      mem[1] = 16'h40FE;
      Z = z_in;
      do_reset;
      for (int i = 0; i < 6; i++) tick;
      checks++; if (bus.imem_addr !== 8'h02) begin errors++; $display("FAIL bz_exec_pc z=%b got %h exp 02", z_in, bus.imem_addr); end
      Z = ~z_in;
      tick;
      checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_pc})
         begin errors++; $display("FAIL bz_target z=%b got %h exp %h", z_in, {bus.imem_req, bus.imem_addr}, {1'b1, exp_pc}); end
      Z = 1'b0;
   endtask

   task test_lhi_out;
      clear_mem;
      mem[0] = 16'h2BAB;
      mem[1] = 16'h3860;
      do_reset;
      tick;
      checks++; if ({LHI, LLI, out_imm, ext_B_data, RF_addr} !== {1'b1, 1'b0, 1'b1, 16'h00AB, 3'd3})
         begin errors++; $display("FAIL lhi_decode got %h exp %h", {LHI, LLI, out_imm, ext_B_data, RF_addr}, {1'b1, 1'b0, 1'b1, 16'h00AB, 3'd3}); end
      tick;
      checks++; if ({RF_en, ctro_outR} !== 2'b00) begin errors++; $display("FAIL lhi_exec got %b exp 00", {RF_en, ctro_outR}); end
      tick;
      checks++; if ({RF_en, RF_addr} !== {1'b1, 3'd3}) begin errors++; $display("FAIL lhi_wb got %b exp 1011", {RF_en, RF_addr}); end
      tick; tick;
      checks++; if ({read_A, LHI, out_imm} !== {3'd3, 1'b0, 1'b0}) begin errors++; $display("FAIL out_decode got %b exp 01100", {read_A, LHI, out_imm}); end
      tick;
      checks++; if ({ctro_outR, RF_en} !== 2'b10) begin errors++; $display("FAIL out_strobe got %b exp 10", {ctro_outR, RF_en}); end
      tick;
      checks++; if ({ctro_outR, RF_en, bus.imem_req} !== 3'b001) begin errors++; $display("FAIL out_after got %b exp 001", {ctro_outR, RF_en, bus.imem_req}); end
   endtask

   task test_halt_illegal;
      clear_mem;
      mem[0] = 16'hA800;
      mem[1] = 16'hF800;
      do_reset;
      tick;
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_early got %b exp 0", illegal); end
      tick; tick;
      checks++; if ({illegal, bus.imem_addr} !== {1'b1, 8'h01}) begin errors++; $display("FAIL illegal_set got %h exp 101", {illegal, bus.imem_addr}); end
      tick; tick; tick;
      checks++; if ({halted, illegal, bus.imem_req} !== 3'b110) begin errors++; $display("FAIL halt_enter got %b exp 110", {halted, illegal, bus.imem_req}); end
      for (int i = 0; i < 6; i++) tick;
      checks++; if ({halted, illegal, bus.imem_req, RF_en, ctro_outR} !== 5'b11000)
         begin errors++; $display("FAIL halt_stay got %b exp 11000", {halted, illegal, bus.imem_req, RF_en, ctro_outR}); end
   endtask

   task test_jmp_wrap;
      clear_mem;
      mem[0]   = 16'h48FD;
      mem[254] = 16'h4802;
      do_reset;
      tick; tick; tick;
      checks++; if (bus.imem_addr !== 8'hFE) begin errors++; $display("FAIL jmp_fwd got %h exp fe", bus.imem_addr); end
      tick;
      checks++; if (bus.imem_addr !== 8'hFF) begin errors++; $display("FAIL jmp_inc got %h exp ff", bus.imem_addr); end
      tick; tick;
      checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h01}) begin errors++; $display("FAIL jmp_wrap got %h exp 101", {bus.imem_req, bus.imem_addr}); end
   endtask

   task test_reset_mid;
      clear_mem;
      mem[0] = 16'hA800;
      mem[1] = 16'h0A24;
      Z = 1'b1;
      do_reset;
      for (int i = 0; i < 6; i++) tick;
      checks++; if ({RF_en, illegal} !== 2'b11) begin errors++; $display("FAIL mid_wb got %b exp 11", {RF_en, illegal}); end
      rst = 1'b1;
      #1;
      checks++; if ({RF_en, illegal, halted, bus.imem_req, bus.imem_addr} !== {4'b0000, 8'h00})
         begin errors++; $display("FAIL mid_async got %h exp 0", {RF_en, illegal, halted, bus.imem_req, bus.imem_addr}); end
      mem[0] = 16'h40FE;
      do_reset;
      checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL mid_refetch got %h exp 100", {bus.imem_req, bus.imem_addr}); end
      tick; tick; tick;
      checks++; if (bus.imem_addr !== 8'h01) begin errors++; $display("FAIL mid_flags_cleared got %h exp 01", bus.imem_addr); end
      Z = 1'b0;
   endtask

   initial begin
      clear_mem;
      test_reset;
      test_alu;
      test_wait;
      test_branch(1'b1, 8'h00);
      test_branch(1'b0, 8'h02);
      test_lhi_out;
      test_halt_illegal;
      test_jmp_wrap;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
